// File: rtl/rr_lock_arb.sv
// rr_lock_arb: round-robin arbiter whose grant stays locked for a whole
// transaction. The grant is released by i_ack & i_last. On release the next
// winner is loaded in the same cycle, so back-to-back transactions have no
// idle cycle between them.
module rr_lock_arb #(
    parameter  int W  = 4,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_req,
    input  logic          i_ack,
    input  logic          i_last,
    output logic [W-1:0]  o_gnt,
    output logic          o_gnt_vld,
    output logic [IW-1:0] o_gnt_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [W-1:0]    gnt, gnt_nxt;
    logic [IW-1:0]   gnt_id, gnt_id_nxt;

    logic            rel;       // release of the locked transaction this cycle
    logic [IW-1:0]   rel_ptr;   // priority pointer that applies after a release
    logic [IW-1:0]   sel_ptr;   // pointer used by the selection this cycle
    logic            hit;
    logic            found;
    logic [IW-1:0]   sel_id;
    logic [W-1:0]    sel;

    // Work out the release condition and the pointer the selection should use.
    // NOTE: every signal written in an always_comb gets a value before any
    // branch; a path that left one unassigned would infer a latch.
    always_comb begin
        rel     = (state == BUSY) && i_ack && i_last;
        // W need not be a power of two, so wrap at W-1 and not at 2^IW-1.
        rel_ptr = (gnt_id == IW'(W - 1)) ? '0 : gnt_id + IW'(1);
        sel_ptr = (state == BUSY) ? rel_ptr : ptr;
    end

    // Two LSB-first priority selects: requests at or above sel_ptr first, then
    // all requests, which handles the wrap-around.
    always_comb begin
        hit    = |i_req;
        found  = 1'b0;
        sel_id = '0;
        for (int i = 0; i < W; i++) begin
            if (!found && i_req[i] && (i >= int'(sel_ptr))) begin
                found  = 1'b1;
                sel_id = IW'(i);
            end
        end
        for (int i = 0; i < W; i++) begin
            if (!found && i_req[i]) begin
                found  = 1'b1;
                sel_id = IW'(i);
            end
        end
        sel = hit ? ({{(W - 1){1'b0}}, 1'b1} << sel_id) : '0;
    end

    // Next-state logic: take a grant in IDLE, hold it in BUSY until release.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt  = BUSY;
                    gnt_nxt    = sel;
                    gnt_id_nxt = sel_id;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_nxt = rel_ptr;
                    if (hit) begin
                        gnt_nxt    = sel;
                        gnt_id_nxt = sel_id;
                    end else begin
                        state_nxt  = IDLE;
                        gnt_nxt    = '0;
                        gnt_id_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset; reset wins over a release.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
        end
    end

    assign o_gnt     = gnt;
    assign o_gnt_vld = |gnt;
    assign o_gnt_id  = gnt_id;

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) $onehot0(o_gnt));
    a_vld:    assert property (@(posedge clk) o_gnt_vld == (|o_gnt));
    a_locked: assert property (@(posedge clk) disable iff (rst)
                  ($past(state) == BUSY && !$past(rel) && !$past(rst)) |-> $stable(o_gnt));
`endif

endmodule
